// File: rtl/mem_if_pkg.sv
// Shared types and constants for the core's data-memory access interface.
//   mem_resp_state_t : responder FSM states (IDLE -> WAIT -> RESP)
//   mem_req_t        : request payload {write, addr, wdata, be}; the memory_access stage drives it
package mem_if_pkg;

    localparam int unsigned WORD_OFF_W = 2;
    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_BE_W   = DEF_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_resp_state_t;

    typedef struct packed {
        logic                  write;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
        logic [DEF_BE_W-1:0]   be;
    } mem_req_t;

endpackage

// File: rtl/sp_word_ram.sv
// Single-port word RAM with a byte-enable write and a synchronous read.
//   clk   : clock
//   en    : port enable. we=1 writes the enabled byte lanes; we=0 loads rdata.
//   we    : write select
//   be    : byte lane enables for writes
//   idx   : word index
//   wdata : write data
//   rdata : read data, registered. It holds its value until the next read.
// Contents are not reset.
module sp_word_ram #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned IDX_W       = 8
) (
    input  logic                clk,
    input  logic                en,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [IDX_W-1:0]    idx,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata
);

    localparam int unsigned BE_W = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Byte-lane write or registered read. Lanes with be=0 keep their old value.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (be[b]) begin
                        mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
                    end
                end
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's data-memory interface.
// It accepts one load or store at a time and models a fixed access latency.
// It returns load data, or a write acknowledge, over a valid/ready handshake.
//   clk, rst_n            : clock and asynchronous active-low reset
//   req_valid / req_ready : request handshake. req_ready is high only while idle.
//   req_write             : 1 = store, 0 = load
//   req_addr              : byte address. It must be word-aligned.
//   req_wdata, req_be     : store data and byte enables
//   resp_valid/resp_ready : response handshake
//   resp_rdata            : load data. It is 0 for stores and for errors.
//   resp_err              : misaligned or out-of-range request
module data_mem_responder
    import mem_if_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W = 4;

    mem_resp_state_t   state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cap_write_q, cap_write_d;
    logic [IDX_W-1:0]  cap_idx_q, cap_idx_d;
    logic [DATA_W-1:0] cap_wdata_q, cap_wdata_d;
    logic [BE_W-1:0]   cap_be_q, cap_be_d;
    logic              cap_err_q, cap_err_d;

    logic              req_ready_d;
    logic              resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_d;
    logic              resp_err_d;

    logic              ram_en;
    logic              ram_we;
    logic [IDX_W-1:0]  ram_idx;
    logic [DATA_W-1:0] ram_rdata;
    logic [IDX_W-1:0]  req_idx;
    logic              req_err;

    // A request is in error if it is misaligned or its full word index lies beyond the RAM.
    // Upper address bits are compared, so they never alias into the RAM.
    function automatic logic addr_err(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] word;
        word = a >> WORD_OFF_W;
        return (a[WORD_OFF_W-1:0] != '0) || (word >= ADDR_W'(DEPTH_WORDS));
    endfunction

    assign req_idx = req_addr[WORD_OFF_W +: IDX_W];
    assign req_err = addr_err(req_addr);

    sp_word_ram #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .be    (cap_be_q),
        .idx   (ram_idx),
        .wdata (cap_wdata_q),
        .rdata (ram_rdata)
    );

    // State, counter, captured request and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cap_write_q <= 1'b0;
            cap_idx_q   <= '0;
            cap_wdata_q <= '0;
            cap_be_q    <= '0;
            cap_err_q   <= 1'b0;
            req_ready   <= 1'b0;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cap_write_q <= cap_write_d;
            cap_idx_q   <= cap_idx_d;
            cap_wdata_q <= cap_wdata_d;
            cap_be_q    <= cap_be_d;
            cap_err_q   <= cap_err_d;
            req_ready   <= req_ready_d;
            resp_valid  <= resp_valid_d;
            resp_rdata  <= resp_rdata_d;
            resp_err    <= resp_err_d;
        end
    end

    // Next-state logic and RAM control.
    // The FSM always passes through WAIT, so resp_valid rises LATENCY edges after the accept edge.
    // The RAM read is issued one edge before RESP entry, so the registered read data
    // is ready to capture on the RESP-entry edge.
    // A store is committed on the RESP-entry edge and on no other edge.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cap_write_d  = cap_write_q;
        cap_idx_d    = cap_idx_q;
        cap_wdata_d  = cap_wdata_q;
        cap_be_d     = cap_be_q;
        cap_err_d    = cap_err_q;
        req_ready_d  = req_ready;
        resp_valid_d = resp_valid;
        resp_rdata_d = resp_rdata;
        resp_err_d   = resp_err;
        ram_en       = 1'b0;
        ram_we       = 1'b0;
        ram_idx      = cap_idx_q;

        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready) begin
                    cap_write_d = req_write;
                    cap_idx_d   = req_idx;
                    cap_wdata_d = req_wdata;
                    cap_be_d    = req_be;
                    cap_err_d   = req_err;
                    req_ready_d = 1'b0;
                    cnt_d       = CNT_W'(LATENCY - 1);
                    state_d     = WAIT;
                    if (LATENCY == 1 && !req_write && !req_err) begin
                        ram_en  = 1'b1;
                        ram_idx = req_idx;
                    end
                end
            end

            WAIT: begin
                if (cnt_q == '0) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = cap_err_q;
                    resp_rdata_d = '0;
                    if (!cap_err_q) begin
                        if (cap_write_q) begin
                            ram_en = 1'b1;
                            ram_we = 1'b1;
                        end else begin
                            resp_rdata_d = ram_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1) && !cap_write_q && !cap_err_q) begin
                        ram_en = 1'b1;
                    end
                end
            end

            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
